// File: rtl/mem_seq_pkg.sv
// Shared types and timing constants for the word-to-byte RAM sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        RESP
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int RD_LATENCY     = 6;
    localparam int WR_LATENCY     = 5;

endpackage

// File: rtl/mem_word_byte_sequencer.sv
// Splits 32-bit word requests into four little-endian byte accesses on an 8-bit RAM.
// Optional MEM_SEQ_ALIGN_CHECK_EN rejects misaligned requests with rsp_err.
module mem_word_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_din,
    output logic                  ram_write_en,
    input  logic [7:0]            ram_dout
);

    state_t                state, state_nxt;
    logic [1:0]            k;
    logic [1:0]            k_inc;
    logic [1:0]            k_dec;
    logic                  we_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  hs;
    logic                  misalign;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign hs        = req_valid && req_ready;
    assign req_base  = req_addr & ~ADDR_WIDTH'(3);
    assign k_inc     = k + 2'd1;
    assign k_dec     = k - 2'd1;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    assign misalign = |req_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = misalign ? RESP : ACCESS;
            ACCESS:  if (k == 2'd3) state_nxt = we_q ? RESP : DRAIN;
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port signals are registered: each ACCESS cycle shows the address/data
    // loaded on the edge that entered it, so byte k is driven in ACCESS cycle k.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k            <= 2'd0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            base_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            ram_addr     <= '0;
            ram_din      <= '0;
            ram_write_en <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            ram_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        k       <= 2'd0;
                        we_q    <= req_we;
                        err_q   <= misalign;
                        base_q  <= req_base;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (!misalign) begin
                            ram_addr     <= req_base;
                            ram_din      <= req_wdata[7:0];
                            ram_write_en <= req_we && req_be[0];
                        end
                    end
                end
                ACCESS: begin
                    k <= k_inc;
                    if (k != 2'd3) begin
                        ram_addr     <= base_q + ADDR_WIDTH'(k_inc);
                        ram_din      <= wdata_q[{k_inc, 3'b000} +: 8];
                        ram_write_en <= we_q && be_q[k_inc];
                    end
                    // ram_dout carries the byte addressed one cycle earlier
                    if (!we_q && k != 2'd0)
                        rsp_rdata[{k_dec, 3'b000} +: 8] <= ram_dout;
                end
                DRAIN:   rsp_rdata[31:24] <= ram_dout;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_byte_sequencer.sv
// Randomized self-checking bench with a byte-array reference model and a behavioural RAM.
module tb_mem_word_byte_sequencer;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din, ram_dout;
    logic          ram_write_en;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  mem     [0:(1<<AW)-1];
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    mem_word_byte_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_write_en(ram_write_en),
        .ram_dout(ram_dout)
    );

    // behavioural single-port RAM: registered address, one-cycle read latency
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [AW-1:0] base);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[base + AW'(b)];
        return w;
    endfunction

    function automatic logic [31:0] ram_word(input logic [AW-1:0] base);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[base + AW'(b)];
        return w;
    endfunction

    // one full request: timing, RAM traffic and response checked against the model
    task automatic txn(input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
        logic [AW-1:0] base;
        logic          rej;
        int            exp_rsp, rsp_c, bad;
        logic [31:0]   wmask, wmask_exp, exp_rd;
        base = addr & ~AW'(3);
        rej  = 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
        rej = (addr[1:0] != 2'd0);
`endif
        exp_rsp   = rej ? 1 : (we ? 5 : 6);
        wmask_exp = '0;
        if (we && !rej) wmask_exp[4:1] = be;
        exp_rd = (we || rej) ? last_rdata : ref_word(base);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_c = 0; wmask = '0; bad = 0;
        for (int c = 1; c <= 10 && rsp_c == 0; c++) begin
            @(negedge clk);
            if (ram_write_en) begin
                wmask[c] = 1'b1;
                if (c > 4 || ram_din !== wd[8*(c-1) +: 8]) bad++;
            end
            if (!rej && c <= 4 && ram_addr !== base + AW'(c-1)) bad++;
            if (rsp_valid) begin
                rsp_c = c;
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, rej});
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("ready_busy", {31'd0, req_ready}, 32'd0);
            end
        end
        chk("rsp_cycle", rsp_c, exp_rsp);
        chk("wr_mask", wmask, wmask_exp);
        chk("addr_din", bad, 0);
        @(negedge clk);
        chk("ready_ret", {31'd0, req_ready}, 32'd1);

        if (!rej && we)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[base + AW'(b)] = wd[8*b +: 8];
        if (!rej && !we) last_rdata = exp_rd;
    endtask

    initial begin
        int n, pulses, rc;
        logic [31:0] w;
        for (int i = 0; i < (1<<AW); i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        last_rdata = '0;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, ram_write_en}, 32'd0);
        chk("rst_addr", {18'd0, ram_addr}, 32'd0);
        chk("rst_data", rsp_rdata | {24'd0, ram_din}, 32'd0);
        reset_n = 1'b1;

        // basic word write and readback
        txn(1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
        chk("ram_deadbeef", ram_word(14'h0010), 32'hDEADBEEF);
        txn(1'b0, 14'h0010, 32'h0, 4'h0);
        chk("rd_deadbeef", rsp_rdata, 32'hDEADBEEF);

        // partial byte enables
        txn(1'b1, 14'h0020, 32'h11223344, 4'hF);
        txn(1'b1, 14'h0020, 32'hAABBCCDD, 4'b0101);
        txn(1'b0, 14'h0020, 32'h0, 4'h0);
        chk("be_merge", rsp_rdata, 32'h11BB33DD);
        txn(1'b1, 14'h0020, 32'h99999999, 4'h0);
        chk("be_none", ram_word(14'h0020), 32'h11BB33DD);

        // top word of the address space
        txn(1'b1, 14'h3FFC, 32'hC0FFEE42, 4'hF);
        txn(1'b0, 14'h3FFC, 32'h0, 4'h0);
        chk("top_word", rsp_rdata, 32'hC0FFEE42);

        // back-to-back reads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0010;
        @(posedge clk);
        n = 0; pulses = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (req_ready) begin n = c; break; end
        end
        chk("b2b_gap", n, 7);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rc = 0;
        for (int c = 1; c <= 10 && rc == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) begin rc = c; pulses++; chk("b2b_rdata", rsp_rdata, ref_word(14'h0010)); end
        end
        chk("b2b_rsp_cycle", rc, 6);
        chk("b2b_pulses", pulses, 2);
        last_rdata = ref_word(14'h0010);
        @(negedge clk);

        // reset during write cycle 3: bytes 0-1 land, 2-3 stay
        txn(1'b1, 14'h0040, 32'h01020304, 4'hF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0040; req_wdata = 32'h55667788; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {29'd0, rsp_valid, ram_write_en, rsp_err}, 32'd0);
        chk("mid_rst_addr", {18'd0, ram_addr}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        pulses = 0;
        repeat (3) begin @(posedge clk); #1 if (rsp_valid) pulses++; end
        chk("mid_rst_norsp", pulses, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("partial_write", ram_word(14'h0040), 32'h01027788);
        ref_mem[14'h0040] = 8'h88; ref_mem[14'h0041] = 8'h77;
        last_rdata = '0;
        txn(1'b0, 14'h0040, 32'h0, 4'h0);

        // misaligned requests
        txn(1'b0, 14'h0013, 32'h0, 4'h0);
        txn(1'b1, 14'h0013, 32'hCAFEF00D, 4'hF);
        txn(1'b0, 14'h0010, 32'h0, 4'h0);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? (14'h3FF0 + AW'($urandom_range(0, 15)))
                                            : AW'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_word_byte_sequencer.md
# mem_word_byte_sequencer

Initiator-side adapter that serves 32-bit word read/write requests from the MCU data bus on an 8-bit single-port RAM (registered address, one-cycle read latency). Each request is split into four sequential byte accesses, little-endian. On reads the returned bytes are assembled into one word. It sits between the bus-side load/store logic and the byte-wide RAM port, and is the only master of that port.

## Interface
- ADDR_WIDTH, 14, RAM byte-address width; also the request address width.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address of the word.
- req_wdata  in  32  write data; byte k = bits [8k+7:8k].
- req_be  in  4  write byte enables; ignored on reads.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  assembled read data, valid with rsp_valid on reads; holds its last value otherwise.
- rsp_err  out  1  misalignment flag, valid with rsp_valid.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_din  out  8  RAM write data.
- ram_write_en  out  1  RAM write strobe.
- ram_dout  in  8  RAM read data; shows the byte at the ram_addr sampled on the previous edge.

## Operation
- Handshake: latch req_we, base address, req_wdata, req_be; go to ACCESS.
- Base address: req_addr with bits [1:0] forced to 0, unless the alignment check below rejects the request.
- FSM states:
  - IDLE: on handshake, go to ACCESS.
  - ACCESS: a 2-bit byte counter k runs 0..3. In each ACCESS cycle, registered ram_addr = base + k. After k = 3, a read goes to DRAIN and a write goes to RESP.
  - DRAIN: reads only; captures byte 3, then goes to RESP.
  - RESP: rsp_valid = 1, then go to IDLE.
- Write byte k: ram_din = wdata byte k and ram_write_en = be[k]. A disabled byte still takes its cycle, so latency is fixed. req_be = 0 performs no RAM write but still gives rsp_valid.
- Read byte k: ram_write_en = 0. Capture ram_dout into rsp_rdata[8k+7:8k] one cycle after address k is driven. Reads always return all 4 bytes.
- Address arithmetic is modulo 2^ADDR_WIDTH. Aligned bases never wrap inside a word.
- Outside ACCESS: ram_write_en = 0 and ram_addr holds its value.
- Reset values: state IDLE, so req_ready = 1 during reset. All other outputs are 0.
- Reset mid-operation: abort immediately with no rsp_valid. Bytes already written stay written (a partial write is possible).
- req_valid while busy is ignored; the requester must hold it until ready.

## Timing
Cycle 0 is the handshake edge.
- Read: ram_addr = base+0..3 in cycles 1–4. Captures in cycles 2–5. rsp_valid in cycle 6. req_ready returns in cycle 7. Issue-to-issue interval is 7 cycles.
- Write: byte writes in cycles 1–4. rsp_valid in cycle 5. req_ready in cycle 6.
- Rejected misaligned request (macro on): rsp_valid in cycle 1 with no RAM access; req_ready in cycle 2.

## Configuration
- MEM_SEQ_ALIGN_CHECK_EN defined:
  - req_addr[1:0] != 0 skips ACCESS and goes straight to RESP with rsp_err = 1.
  - No RAM write occurs and rsp_rdata is unchanged.
- Undefined: req_addr[1:0] are ignored (word access at the aligned base) and rsp_err is tied to 0.

## Structure
- Package mem_seq_pkg holds:
  - state enum {IDLE, ACCESS, DRAIN, RESP};
  - BYTES_PER_WORD = 4;
  - RD_LATENCY = 6 and WR_LATENCY = 5.
- Single module; no sub-module. Byte-lane select and capture are a few lines of logic.
- The bench pairs the DUT with the team's behavioural 8-bit single-port RAM model (ADDR_WIDTH = 14).

## Test plan
- Write 0xDEADBEEF, be=4'hF, addr 0x0010, then read 0x0010 → RAM[0x10..0x13] = EF,BE,AD,DE; read rsp_rdata = 0xDEADBEEF at cycle 6; write rsp_valid at cycle 5.
- Preload 0x11223344 at 0x20, then write 0xAABBCCDD with be=4'b0101 → readback 0x11BB33DD; RAM writes only in cycles 1 and 3.
- Top word: write/read at addr 2^14−4 → correct data; ram_addr never exceeds 0x3FFF.
- Back-to-back reads with req_valid held high → second handshake in cycle 7; req_valid during busy is not accepted.
- reset_n low in write cycle 3 → outputs zero immediately and no rsp_valid; bytes 0–1 written, bytes 2–3 untouched; the next request completes normally.
- Misaligned addr 0x0013:
  - macro on → rsp_err = 1 at cycle 1 and no RAM activity;
  - macro off → access to 0x0010 with rsp_err = 0.
